// File: rtl/fp_mult_pkg.sv
// Shared definitions for the FP word format: exception codes, exponent bias
// and construction of the header of non-normal result words.
package fp_mult_pkg;

    typedef enum logic [1:0] {
        EXN_ZERO   = 2'b00,
        EXN_NORMAL = 2'b01,
        EXN_INF    = 2'b10,
        EXN_NAN    = 2'b11
    } exn_e;

    function automatic int unsigned bias(input int unsigned we);
        return (32'd1 << (we - 1)) - 32'd1;
    endfunction

    // {exn, sign} header of a zero/inf/NaN word; the caller appends zero exp/frac.
    // NaN is canonical, so its sign is forced to 0.
    function automatic logic [2:0] special_hdr(input exn_e exn, input logic sign);
        return {exn, (exn == EXN_NAN) ? 1'b0 : sign};
    endfunction

endpackage

// File: rtl/fp_mult_round.sv
// Combinational back end of the multiplier: normalize the mantissa product,
// round to nearest even, range-check the exponent and pack the result word.
module fp_mult_round
    import fp_mult_pkg::*;
#(
    parameter int WE = 5,
    parameter int WF = 6
) (
    input  logic [1:0]         i_exn,
    input  logic               i_sign,
    input  logic [WE+1:0]      i_exp,
    input  logic [2*WF+1:0]    i_prod,
    output logic [WE+WF+2:0]   o_word
);

    localparam logic [WE+1:0] EXP_MAX = {2'b00, {WE{1'b1}}};

    logic            w_msb;
    logic [WF-1:0]   w_frac;
    logic            w_guard;
    logic            w_sticky;
    logic            w_rnd;
    logic [WF:0]     w_frac_sum;
    logic [WE+1:0]   w_exp_n;
    logic [WE+1:0]   w_exp_r;

    always_comb begin
        w_msb = i_prod[2*WF+1];
        if (w_msb) begin
            w_frac   = i_prod[2*WF:WF+1];
            w_guard  = i_prod[WF];
            w_sticky = |i_prod[WF-1:0];
        end else begin
            w_frac   = i_prod[2*WF-1:WF];
            w_guard  = i_prod[WF-1];
            w_sticky = |i_prod[WF-2:0];
        end
        w_rnd      = w_guard & (w_sticky | w_frac[0]);
        // A carry out of the fraction leaves the stored fraction at zero.
        w_frac_sum = {1'b0, w_frac} + {{WF{1'b0}}, w_rnd};
        w_exp_n    = i_exp + {{(WE+1){1'b0}}, w_msb};
        w_exp_r    = w_exp_n + {{(WE+1){1'b0}}, w_frac_sum[WF]};

        o_word = '0;
        if (i_exn != EXN_NORMAL) begin
            o_word = {special_hdr(exn_e'(i_exn), i_sign), {(WE+WF){1'b0}}};
        end else if (w_exp_r[WE+1]) begin
            o_word = {special_hdr(EXN_ZERO, i_sign), {(WE+WF){1'b0}}};
        end else if (w_exp_r > EXP_MAX) begin
            o_word = {special_hdr(EXN_INF, i_sign), {(WE+WF){1'b0}}};
        end else begin
            o_word = {EXN_NORMAL, i_sign, w_exp_r[WE-1:0], w_frac_sum[WF-1:0]};
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined FP multiplier with a valid/ready handshake; every
// stage advances together whenever the output register is free or drained.
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int WE = 5,
    parameter int WF = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WE+WF+2:0]    x,
    input  logic [WE+WF+2:0]    y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WE+WF+2:0]    r
);

    localparam int W = WE + WF + 3;
    localparam logic [WE+1:0] BIAS_E = (WE+2)'(bias(WE));

    logic              w_advance;
    exn_e              w_x_exn;
    exn_e              w_y_exn;
    exn_e              w_exn;
    logic [W-1:0]      w_round_word;

    logic              r_s1_valid;
    exn_e              r_s1_exn;
    logic              r_s1_sign;
    logic [WE+1:0]     r_s1_exp;
    logic [WF:0]       r_s1_mx;
    logic [WF:0]       r_s1_my;

    logic              r_s2_valid;
    exn_e              r_s2_exn;
    logic              r_s2_sign;
    logic [WE+1:0]     r_s2_exp;
    logic [2*WF+1:0]   r_s2_prod;

    logic              r_out_valid;
    logic [W-1:0]      r_out;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign r         = r_out;

    always_comb begin
        w_x_exn = exn_e'(x[W-1:W-2]);
        w_y_exn = exn_e'(y[W-1:W-2]);
        w_exn   = EXN_NORMAL;
        if (w_x_exn == EXN_NAN || w_y_exn == EXN_NAN ||
            (w_x_exn == EXN_ZERO && w_y_exn == EXN_INF) ||
            (w_x_exn == EXN_INF && w_y_exn == EXN_ZERO)) begin
            w_exn = EXN_NAN;
        end else if (w_x_exn == EXN_INF || w_y_exn == EXN_INF) begin
            w_exn = EXN_INF;
        end else if (w_x_exn == EXN_ZERO || w_y_exn == EXN_ZERO) begin
            w_exn = EXN_ZERO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_exn   <= EXN_ZERO;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_mx    <= '0;
            r_s1_my    <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_exn  <= w_exn;
                r_s1_sign <= x[WE+WF] ^ y[WE+WF];
                r_s1_exp  <= {2'b00, x[WE+WF-1:WF]} + {2'b00, y[WE+WF-1:WF]} - BIAS_E;
                r_s1_mx   <= {1'b1, x[WF-1:0]};
                r_s1_my   <= {1'b1, y[WF-1:0]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_exn   <= EXN_ZERO;
            r_s2_sign  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_prod  <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            r_s2_exn   <= r_s1_exn;
            r_s2_sign  <= r_s1_sign;
            r_s2_exp   <= r_s1_exp;
            r_s2_prod  <= {{(WF+1){1'b0}}, r_s1_mx} * {{(WF+1){1'b0}}, r_s1_my};
        end
    end

    fp_mult_round #(
        .WE(WE),
        .WF(WF)
    ) u_round (
        .i_exn  (r_s2_exn),
        .i_sign (r_s2_sign),
        .i_exp  (r_s2_exp),
        .i_prod (r_s2_prod),
        .o_word (w_round_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out <= w_round_word;
            end
        end
    end

endmodule
